vector_deser: RTL and testbench
===============================

Name: vector_deser

Overview:
Bit-serial to parallel deserializer that sits directly upstream of the vector ones-count stage. It packs a stream of single bits, LSB first, into DATA_W-bit vectors. Each completed vector is presented on a valid/ready output port. The block has a single-word output buffer and applies backpressure to the serial side, so no bit is ever dropped.

Parameters:
DATA_W, 10, width of each assembled vector (must be >= 2)
CNT_W, $clog2(DATA_W), width of the bit-position counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
ser_valid  input  1  ser_bit carries a valid bit this cycle
ser_bit  input  1  serial data bit
ser_ready  output  1  block accepts ser_bit this cycle
out_valid  output  1  out_data holds a complete vector
out_data  output  DATA_W  assembled vector; bit 0 is the first bit received
out_ready  input  1  downstream consumes out_data this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - out_valid=0, out_data=0.
  - Internal assembly register asm=0, bit counter cnt=0.
  - ser_ready=1 after reset.
- Serial accept: a bit is accepted when ser_valid && ser_ready on a rising edge.
  - Accepted bit is written to asm[cnt].
  - If cnt < DATA_W-1: cnt increments.
  - If cnt == DATA_W-1 (completing bit): the full vector {ser_bit, asm[DATA_W-2:0]} loads into out_data, out_valid is set, cnt wraps to 0 and asm clears to 0.
- Output handshake: transfer occurs when out_valid && out_ready.
  - out_data and out_valid are held stable while out_valid && !out_ready.
  - On transfer with no new completion in the same cycle, out_valid clears next cycle. out_data retains its last value.
- Latency: out_valid rises on the clock edge that accepts the completing bit, i.e. it is visible the cycle after that bit is presented.
- Backpressure:
  - ser_ready = !(cnt == DATA_W-1 && out_valid && !out_ready).
  - ser_ready is combinational from out_ready; this path is intended.
  - Non-completing bits are accepted even while the output is stalled, so assembly of the next word proceeds during a stall.
- Simultaneous events: a transfer of the old word and acceptance of a completing bit in the same cycle → out_valid stays 1 and out_data loads the new word. No bubble.
- Throughput: sustained 1 bit/cycle and one word per DATA_W cycles with out_ready held high.
- ser_valid gaps: cnt and asm hold. ser_bit is ignored when ser_valid=0.
- Reset mid-word: the partial word is discarded and any pending out_valid is dropped. The next accepted bit starts at position 0.
- Implementation: no combinational path from ser_bit or ser_valid to any output.

Optional Feature:
Macro VECTOR_DESER_FLUSH_EN.
- Defined: adds these ports:
  - input ser_last (1 bit): marks the final bit of a frame.
  - output out_len (CNT_W+1 bits): number of valid bits in out_data.
- Flush behaviour with the macro defined:
  - An accepted bit with ser_last=1 completes the word regardless of cnt.
  - out_data = assembled bits with positions above cnt forced to 0. out_len = cnt+1.
  - Full words report out_len=DATA_W.
  - ser_ready also drops for a ser_last bit when the output is stalled, i.e. the ser_ready condition becomes (cnt == DATA_W-1 || ser_last).
  - Reset value: out_len=0.
- Undefined: ports ser_last and out_len do not exist, and words complete only at cnt == DATA_W-1.

Test Plan:
1. Reset check: hold rst_n=0, then release → out_valid=0, out_data=0, ser_ready=1. Asserting rst_n low asynchronously between clock edges clears out_valid immediately.
2. Single word, DATA_W=10, out_ready=1: bits 1,0,1,1,0,0,0,0,0,1 on consecutive cycles → out_valid=1 for exactly one cycle, starting the cycle after the 10th bit, with out_data=10'h20D.
3. Back-to-back words, out_ready=1: 30 continuous bits → three out_valid pulses spaced 10 cycles apart, with ser_ready constantly 1.
4. Stall, out_ready=0:
   - Stream 2 words (first all-ones, second 10'h155) → first word (10'h3FF) held; 9 bits of the second accepted; ser_ready=0 with cnt=9.
   - Raise out_ready → 10'h3FF transfers and the completing bit is accepted in the same cycle.
   - Next cycle → out_data=10'h155, out_valid=1.
5. Gaps and mid-word reset:
   - Random ser_valid idle cycles inside a word → same out_data as the gap-free run.
   - Pulse rst_n low after 4 accepted bits → next 10 bits form a fresh word, with no output from the discarded partial word.
6. With VECTOR_DESER_FLUSH_EN defined: bits 1,1,0 with ser_last on the 3rd bit → out_data=10'h003, out_len=3. A following full word reports out_len=10.

Source files
------------

// File: rtl/vector_deser.sv
// vector_deser: LSB-first bit-serial to DATA_W-bit parallel deserializer with a one-word valid/ready output buffer.
// Define VECTOR_DESER_FLUSH_EN to add ser_last (early word completion) and out_len.
module vector_deser #(
   parameter int DATA_W = 10,
   parameter int CNT_W  = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ser_valid,
   input  logic              ser_bit,
`ifdef VECTOR_DESER_FLUSH_EN
   input  logic              ser_last,
   output logic [CNT_W:0]    out_len,
`endif
   output logic              ser_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready
);
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] asm_q, asm_d, data_q, data_d, word;
   logic              valid_q, valid_d, last, acc, done;
`ifdef VECTOR_DESER_FLUSH_EN
   logic [CNT_W:0]    len_q, len_d;
   assign last = cnt_q == CNT_W'(DATA_W-1) || ser_last;
   assign len_d = done ? {1'b0, cnt_q} + (CNT_W+1)'(1) : len_q;
   assign out_len = len_q;
`else
   assign last = cnt_q == CNT_W'(DATA_W-1);
`endif
   assign ser_ready = !(last && valid_q && !out_ready);
   assign acc = ser_valid && ser_ready;
   assign done = acc && last;
   // Positions above cnt are still zero since the last clear, so a flushed word needs no masking
   assign word = asm_q | (DATA_W'(ser_bit) << cnt_q);
   assign cnt_d = !acc ? cnt_q : last ? '0 : cnt_q + CNT_W'(1);
   assign asm_d = !acc ? asm_q : last ? '0 : word;
   assign valid_d = done || (valid_q && !out_ready);
   assign data_d = done ? word : data_q;
   assign out_valid = valid_q;
   assign out_data = data_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         asm_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
`ifdef VECTOR_DESER_FLUSH_EN
         len_q   <= '0;
`endif
      end else begin
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         data_q  <= data_d;
         valid_q <= valid_d;
`ifdef VECTOR_DESER_FLUSH_EN
         len_q   <= len_d;
`endif
      end
   end
endmodule

// File: tb/tb_vector_deser.sv
// tb_vector_deser: directed self-checking bench for vector_deser (DATA_W=10).
module tb_vector_deser;
   localparam int DATA_W = 10;
   localparam int CNT_W  = $clog2(DATA_W);
   logic clk = 1'b0, rst_n = 1'b0;
   logic ser_valid = 1'b0, ser_bit = 1'b0, out_ready = 1'b0;
   logic ser_ready, out_valid;
   logic [DATA_W-1:0] out_data;
   int pass_cnt = 0, total = 0;
`ifdef VECTOR_DESER_FLUSH_EN
   logic ser_last = 1'b0;
   logic [CNT_W:0] out_len;
`endif

   vector_deser #(.DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .ser_valid(ser_valid), .ser_bit(ser_bit),
`ifdef VECTOR_DESER_FLUSH_EN
      .ser_last(ser_last), .out_len(out_len),
`endif
      .ser_ready(ser_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic send(input logic b);
      ser_valid = 1'b1;
      ser_bit = b;
      @(posedge clk); #1;
      ser_valid = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_data !== '0 || ser_ready !== 1'b1)
         $display("FAIL reset_hold: valid=%b data=%h ready=%b, want 0 000 1", out_valid, out_data, ser_ready);
      else pass_cnt++;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      idle();
      total++;
      if (out_valid !== 1'b0 || out_data !== '0 || ser_ready !== 1'b1)
         $display("FAIL reset_release: valid=%b data=%h ready=%b, want 0 000 1", out_valid, out_data, ser_ready);
      else pass_cnt++;
   endtask

   task automatic test_single();
      logic [DATA_W-1:0] w;
      w = 10'h20D;
      out_ready = 1'b1;
      for (int i = 0; i < DATA_W; i++) begin
         send(w[i]);
         total++;
         if (out_valid !== (i == DATA_W-1))
            $display("FAIL single_valid bit%0d: valid=%b want %b", i, out_valid, i == DATA_W-1);
         else pass_cnt++;
      end
      total++;
      if (out_data !== 10'h20D) $display("FAIL single_data: got %h want 20d", out_data);
      else pass_cnt++;
      idle();
      total++;
      if (out_valid !== 1'b0 || out_data !== 10'h20D)
         $display("FAIL single_after: valid=%b data=%h want 0 20d", out_valid, out_data);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] w [3];
      int pulses;
      logic ready_ok;
      w[0] = 10'h2A5; w[1] = 10'h0F3; w[2] = 10'h31C;
      pulses = 0;
      ready_ok = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3*DATA_W; i++) begin
         ser_valid = 1'b1;
         ser_bit = w[i/DATA_W][i%DATA_W];
         #1;
         if (ser_ready !== 1'b1) ready_ok = 1'b0;
         @(posedge clk); #1;
         if (out_valid === 1'b1) pulses++;
         if (i % DATA_W == DATA_W-1) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== w[i/DATA_W])
               $display("FAIL b2b_word%0d: valid=%b data=%h want 1 %h", i/DATA_W, out_valid, out_data, w[i/DATA_W]);
            else pass_cnt++;
         end
      end
      ser_valid = 1'b0;
      total++;
      if (pulses !== 3) $display("FAIL b2b_pulses: got %0d want 3", pulses);
      else pass_cnt++;
      total++;
      if (ready_ok !== 1'b1) $display("FAIL b2b_ready: ser_ready dropped, want constant 1");
      else pass_cnt++;
      idle();
   endtask

   task automatic test_stall();
      logic [DATA_W-1:0] w;
      logic hold_ok;
      w = 10'h155;
      hold_ok = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < DATA_W; i++) send(1'b1);
      total++;
      if (out_valid !== 1'b1 || out_data !== 10'h3FF)
         $display("FAIL stall_first: valid=%b data=%h want 1 3ff", out_valid, out_data);
      else pass_cnt++;
      for (int i = 0; i < DATA_W-1; i++) begin
         ser_valid = 1'b1;
         ser_bit = w[i];
         #1;
         if (ser_ready !== 1'b1) hold_ok = 1'b0;
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || out_data !== 10'h3FF) hold_ok = 1'b0;
      end
      total++;
      if (hold_ok !== 1'b1) $display("FAIL stall_hold: valid=%b data=%h want 1 3ff with ready high", out_valid, out_data);
      else pass_cnt++;
      ser_bit = w[DATA_W-1];
      #1;
      total++;
      if (ser_ready !== 1'b0) $display("FAIL stall_ready_low: ser_ready=%b want 0", ser_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== 10'h3FF)
         $display("FAIL stall_still: valid=%b data=%h want 1 3ff", out_valid, out_data);
      else pass_cnt++;
      out_ready = 1'b1;
      #1;
      total++;
      if (ser_ready !== 1'b1) $display("FAIL stall_ready_comb: ser_ready=%b want 1", ser_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      ser_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== 10'h155)
         $display("FAIL stall_second: valid=%b data=%h want 1 155", out_valid, out_data);
      else pass_cnt++;
      idle();
      total++;
      if (out_valid !== 1'b0) $display("FAIL stall_drain: valid=%b want 0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_gaps();
      logic [DATA_W-1:0] w;
      logic early;
      w = 10'h1B6;
      early = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < DATA_W; i++) begin
         repeat ($urandom_range(0, 2)) begin
            ser_valid = 1'b0;
            ser_bit = ~w[i];
            idle();
            if (out_valid !== 1'b0) early = 1'b1;
         end
         send(w[i]);
         if (i < DATA_W-1 && out_valid !== 1'b0) early = 1'b1;
      end
      total++;
      if (out_valid !== 1'b1 || out_data !== 10'h1B6 || early !== 1'b0)
         $display("FAIL gaps_word: valid=%b data=%h early=%b want 1 1b6 0", out_valid, out_data, early);
      else pass_cnt++;
      idle();
   endtask

   task automatic test_mid_reset();
      logic [DATA_W-1:0] w;
      logic early;
      w = 10'h0C5;
      early = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < DATA_W; i++) send(1'b1);
      for (int i = 0; i < 4; i++) send(1'b1);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_data !== '0)
         $display("FAIL async_reset: valid=%b data=%h want 0 000", out_valid, out_data);
      else pass_cnt++;
      @(posedge clk);
      #3 rst_n = 1'b1;
      idle();
      out_ready = 1'b1;
      for (int i = 0; i < DATA_W; i++) begin
         send(w[i]);
         if (i < DATA_W-1 && out_valid !== 1'b0) early = 1'b1;
      end
      total++;
      if (early !== 1'b0) $display("FAIL midreset_partial: early valid=%b want 0", early);
      else pass_cnt++;
      total++;
      if (out_valid !== 1'b1 || out_data !== 10'h0C5)
         $display("FAIL midreset_word: valid=%b data=%h want 1 0c5", out_valid, out_data);
      else pass_cnt++;
      idle();
   endtask

`ifdef VECTOR_DESER_FLUSH_EN
   task automatic test_flush();
      logic [DATA_W-1:0] w;
      w = 10'h2AB;
      out_ready = 1'b1;
      send(1'b1);
      send(1'b1);
      ser_last = 1'b1;
      send(1'b0);
      ser_last = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== 10'h003 || out_len !== 4'd3)
         $display("FAIL flush_short: valid=%b data=%h len=%0d want 1 003 3", out_valid, out_data, out_len);
      else pass_cnt++;
      for (int i = 0; i < DATA_W; i++) send(w[i]);
      total++;
      if (out_valid !== 1'b1 || out_data !== 10'h2AB || out_len !== 4'd10)
         $display("FAIL flush_full: valid=%b data=%h len=%0d want 1 2ab 10", out_valid, out_data, out_len);
      else pass_cnt++;
      idle();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_gaps();
      test_mid_reset();
`ifdef VECTOR_DESER_FLUSH_EN
      test_flush();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
